serializer: RTL and testbench

//  Parallel-to-serial transmitter; the sending end of the link that the deserializer receives.

---
 rtl/ser_pkg.sv | 13 +
 rtl/serializer.sv | 150 +++++++++++++++
 tb/tb_serializer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the serializer: FSM state encoding and default word width.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    GAP    = 2'd3
  } ser_state_t;

  localparam int SER_DATA_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial transmitter: accepts a word on load_in/ready_out and shifts it out MSB-first.
// Optional even-parity bit after the LSB when SERIALIZER_PARITY_EN is defined.
module serializer
  import ser_pkg::*;
#(
  parameter int DATA_WIDTH = SER_DATA_WIDTH_DEFAULT,
  parameter int GAP_CYCLES = 0
) (
  input  logic                  clock_100KHZ,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  load_in,
  output logic                  ready_out,
  output logic                  data_out,
  output logic                  write_out,
  output logic                  done_out
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // Handshake: a word is taken on any rising edge where load_in && ready_out;
  // ready_out is high only in IDLE, so load_in is ignored for the rest of the frame.

  ser_state_t            r_state;
  logic [DATA_WIDTH-1:0] r_shreg;
  logic [BW-1:0]         r_bit_cnt;
  logic [GW-1:0]         r_gap_cnt;
  logic                  r_data_out;
  logic                  r_write_out;
  logic                  r_done_out;

  ser_state_t            w_state;
  logic [DATA_WIDTH-1:0] w_shreg;
  logic [BW-1:0]         w_bit_cnt;
  logic [GW-1:0]         w_gap_cnt;
  logic                  w_data_out;
  logic                  w_write_out;
  logic                  w_done_out;

`ifdef SERIALIZER_PARITY_EN
  logic                  r_parity;
  logic                  w_parity;
`endif

  // bit_cnt counts bits already placed on data_out; the MSB goes out on the accept edge.
  always_comb begin
    w_state     = r_state;
    w_shreg     = r_shreg;
    w_bit_cnt   = r_bit_cnt;
    w_gap_cnt   = r_gap_cnt;
    w_data_out  = 1'b0;
    w_write_out = 1'b0;
    w_done_out  = 1'b0;
`ifdef SERIALIZER_PARITY_EN
    w_parity    = r_parity;
`endif
    case (r_state)
      IDLE: begin
        if (load_in) begin
          w_data_out  = data_in[DATA_WIDTH-1];
          w_write_out = 1'b1;
          w_shreg     = data_in << 1;
          w_bit_cnt   = BW'(1);
          w_state     = SHIFT;
`ifdef SERIALIZER_PARITY_EN
          w_parity    = ^data_in;
`endif
        end
      end
      SHIFT: begin
        if (r_bit_cnt != BIT_LAST) begin
          w_data_out  = r_shreg[DATA_WIDTH-1];
          w_write_out = 1'b1;
          w_shreg     = r_shreg << 1;
          w_bit_cnt   = r_bit_cnt + BW'(1);
`ifndef SERIALIZER_PARITY_EN
          w_done_out  = (r_bit_cnt == BIT_LAST - BW'(1));
`endif
        end else begin
`ifdef SERIALIZER_PARITY_EN
          w_data_out  = r_parity;
          w_write_out = 1'b1;
          w_done_out  = 1'b1;
          w_state     = PARITY;
`else
          if (GAP_CYCLES > 0) begin
            w_gap_cnt = GAP_LOAD;
            w_state   = GAP;
          end else begin
            w_state   = IDLE;
          end
`endif
        end
      end
      PARITY: begin
        if (GAP_CYCLES > 0) begin
          w_gap_cnt = GAP_LOAD;
          w_state   = GAP;
        end else begin
          w_state   = IDLE;
        end
      end
      GAP: begin
        if (r_gap_cnt == '0) begin
          w_state   = IDLE;
        end else begin
          w_gap_cnt = r_gap_cnt - GW'(1);
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_100KHZ or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_gap_cnt   <= '0;
      r_data_out  <= 1'b0;
      r_write_out <= 1'b0;
      r_done_out  <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_state     <= w_state;
      r_shreg     <= w_shreg;
      r_bit_cnt   <= w_bit_cnt;
      r_gap_cnt   <= w_gap_cnt;
      r_data_out  <= w_data_out;
      r_write_out <= w_write_out;
      r_done_out  <= w_done_out;
`ifdef SERIALIZER_PARITY_EN
      r_parity    <= w_parity;
`endif
    end
  end

  assign ready_out = (r_state == IDLE);
  assign data_out  = r_data_out;
  assign write_out = r_write_out;
  assign done_out  = r_done_out;

endmodule

// File: tb/tb_serializer.sv
// Scoreboard bench for serializer: two instances (GAP_CYCLES=0 and 3), expected frames queued
// by the driver and popped by a negedge monitor that reassembles the serial stream.
module tb_serializer;

  localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
  localparam int FW = W + 1;
  localparam logic [FW-1:0] F_A5 = 9'b1010_0101_0;
  localparam logic [FW-1:0] F_81 = 9'b1000_0001_0;
  localparam logic [FW-1:0] F_07 = 9'b0000_0111_1;
`else
  localparam int FW = W;
  localparam logic [FW-1:0] F_A5 = 8'b1010_0101;
  localparam logic [FW-1:0] F_81 = 8'b1000_0001;
  localparam logic [FW-1:0] F_07 = 8'b0000_0111;
`endif

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] d_in  [2];
  logic         load  [2];
  logic         ready [2];
  logic         dout  [2];
  logic         wr    [2];
  logic         done  [2];

  logic [FW-1:0] exp_qa[$];
  logic [FW-1:0] exp_qb[$];

  int n_tests = 0;
  int n_fail  = 0;

  logic [FW-1:0] rx [2];
  int  cnt      [2];
  int  zero     [2];
  int  last_gap [2];
  int  frames   [2];
  bit  seen     [2];

  serializer #(.DATA_WIDTH(W), .GAP_CYCLES(0)) u_dut_a (
    .clock_100KHZ (clk),
    .reset        (rst_n),
    .data_in      (d_in[0]),
    .load_in      (load[0]),
    .ready_out    (ready[0]),
    .data_out     (dout[0]),
    .write_out    (wr[0]),
    .done_out     (done[0])
  );

  serializer #(.DATA_WIDTH(W), .GAP_CYCLES(3)) u_dut_b (
    .clock_100KHZ (clk),
    .reset        (rst_n),
    .data_in      (d_in[1]),
    .load_in      (load[1]),
    .ready_out    (ready[1]),
    .data_out     (dout[1]),
    .write_out    (wr[1]),
    .done_out     (done[1])
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [FW-1:0] exp_frame(input logic [W-1:0] w);
`ifdef SERIALIZER_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  // monitor: rebuilds frames from data_out/write_out and checks them against the scoreboard
  always @(negedge clk) begin
    logic [FW-1:0] e;
    int qn;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        cnt[d]  = 0;
        zero[d] = 0;
        seen[d] = 1'b0;
      end else if (wr[d]) begin
        if (cnt[d] == 0 && seen[d]) last_gap[d] = zero[d];
        rx[d] = {rx[d][FW-2:0], dout[d]};
        cnt[d]++;
        chk("ready_low_in_frame", ready[d], 0);
        chk("done_on_last_bit", done[d], (cnt[d] == FW));
        if (cnt[d] == FW) begin
          qn = (d == 0) ? exp_qa.size() : exp_qb.size();
          chk("frame_expected", (qn > 0), 1);
          if (qn > 0) begin
            e = (d == 0) ? exp_qa.pop_front() : exp_qb.pop_front();
            chk((d == 0) ? "frame_a" : "frame_b", rx[d], e);
          end
          frames[d]++;
          cnt[d]  = 0;
          seen[d] = 1'b1;
          zero[d] = 0;
        end
      end else begin
        if (cnt[d] != 0) begin
          chk("no_bubble", wr[d], 1);
          cnt[d] = 0;
        end
        chk("done_low_idle", done[d], 0);
        zero[d]++;
      end
    end
  end

  // driver tasks
  task automatic wait_ready(input int d);
    int n = 0;
    while (!ready[d] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", ready[d], 1);
  endtask

  task automatic send(input int d, input logic [W-1:0] word, input logic [FW-1:0] exp, input bit push);
    @(negedge clk);
    wait_ready(d);
    d_in[d] = word;
    load[d] = 1'b1;
    if (push) begin
      if (d == 0) exp_qa.push_back(exp);
      else        exp_qb.push_back(exp);
    end
    @(negedge clk);
    load[d] = 1'b0;
    d_in[d] = ~word;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted, required completion before limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    int n;
    for (int d = 0; d < 2; d++) begin
      d_in[d] = '0;
      load[d] = 1'b0;
      frames[d] = 0;
      last_gap[d] = 0;
      rx[d] = '0;
    end
    rst_n = 1'b0;

    // 1: reset then idle; a load during reset must be ignored
    @(negedge clk);
    load[0] = 1'b1;
    d_in[0] = 8'hEE;
    @(negedge clk);
    chk("rst_ready", ready[0], 1);
    chk("rst_write", wr[0], 0);
    chk("rst_done", done[0], 0);
    chk("rst_dout", dout[0], 0);
    load[0] = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    chk("idle_ready_a", ready[0], 1);
    chk("idle_write_a", wr[0], 0);
    chk("idle_done_a", done[0], 0);
    chk("idle_dout_a", dout[0], 0);
    chk("idle_ready_b", ready[1], 1);
    chk("idle_write_b", wr[1], 0);

    // 2: single word 0xA5, MSB on the wire in the cycle after the accept edge
    send(0, 8'hA5, F_A5, 1'b1);
    chk("latency_write", wr[0], 1);
    chk("latency_msb", dout[0], 1);
    chk("busy_ready", ready[0], 0);
    wait_ready(0);
    chk("frames_after_a5", frames[0], 1);

    // 3: load held high, 0x3C then 0xC3 with GAP_CYCLES=0
    @(negedge clk);
    wait_ready(0);
    d_in[0] = 8'h3C;
    load[0] = 1'b1;
    exp_qa.push_back(exp_frame(8'h3C));
    @(negedge clk);
    d_in[0] = 8'hC3;
    exp_qa.push_back(exp_frame(8'hC3));
    @(negedge clk);
    wait_ready(0);
    @(negedge clk);
    load[0] = 1'b0;
    chk("second_frame_started", wr[0], 1);
    @(negedge clk);
    wait_ready(0);
    chk("gap_a", last_gap[0], 1);

    // 4: GAP_CYCLES=3, back-to-back loads then a dropped pulse inside the gap
    @(negedge clk);
    wait_ready(1);
    d_in[1] = 8'h5A;
    load[1] = 1'b1;
    exp_qb.push_back(exp_frame(8'h5A));
    @(negedge clk);
    d_in[1] = 8'h96;
    exp_qb.push_back(exp_frame(8'h96));
    @(negedge clk);
    wait_ready(1);
    @(negedge clk);
    load[1] = 1'b0;
    n = 0;
    while (!done[1] && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen_b", done[1], 1);
    @(negedge clk);
    chk("gap_not_ready", ready[1], 0);
    d_in[1] = 8'h55;
    load[1] = 1'b1;
    @(negedge clk);
    load[1] = 1'b0;
    repeat (30) @(negedge clk);
    chk("gap_b", last_gap[1], 4);
    chk("gap_load_dropped", frames[1], 2);
    chk("b_queue_empty", exp_qb.size(), 0);

    // 5: async reset mid-frame of 0xFF, then 0x81 starts cleanly from the MSB
    send(0, 8'hFF, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_write", wr[0], 0);
    chk("async_rst_dout", dout[0], 0);
    chk("async_rst_done", done[0], 0);
    chk("async_rst_ready", ready[0], 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 8'h81, F_81, 1'b1);
    chk("post_rst_msb", dout[0], 1);

    // 6: 0x07, the all-zero / all-one words, then 50 random words
    send(0, 8'h07, F_07, 1'b1);
    send(0, 8'h00, exp_frame(8'h00), 1'b1);
    send(0, 8'hFF, exp_frame(8'hFF), 1'b1);
    for (int i = 0; i < 50; i++) begin
      w = W'($urandom_range(0, 255));
      send(0, w, exp_frame(w), 1'b1);
    end
    @(negedge clk);
    wait_ready(0);
    repeat (3) @(negedge clk);
    chk("qa_empty", exp_qa.size(), 0);
    chk("qb_empty", exp_qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
